// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path.
//   - fetch_state_e : fetch sequencer states (IDLE, FETCH, ISSUE, HALTED)
//   - OP_HALT/OP_NOP: opcode encodings the fetch unit cares about
//   - DEF_ADDR_W/DEF_INSTR_W: default address and instruction widths
package cpu_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 8;

  localparam logic [DEF_INSTR_W-1:0] OP_HALT = 8'hFF;
  localparam logic [DEF_INSTR_W-1:0] OP_NOP  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller.
// Owns the program counter, reads a combinational instruction memory, registers
// each instruction and offers it to execute, applies taken-branch redirects and
// stops for good once a HALT opcode is fetched.
//
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   start             : one-cycle pulse, leaves IDLE and begins fetching
//   pc_address        : fetch address, straight from the PC register
//   imem_data         : instruction returned combinationally for pc_address
//   instr, instr_pc   : registered instruction and the address it came from
//   instr_valid       : instr/instr_pc valid
//   instr_ready       : execute accepts instr this cycle
//   redirect_valid    : branch taken for the instruction being accepted
//   redirect_target   : branch target address
//   running           : high in FETCH or ISSUE
//   halted            : HALT fetched, sticky until reset
//   retired_count     : accepted instructions, saturating
//   dbg_state_o       : current sequencer state
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. While instr_valid=1 and instr_ready=0, instr,
// instr_pc and instr_valid hold. redirect_valid/redirect_target are sampled
// only on that transfer edge.
module instruction_fetch_controller
  import cpu_pkg::*;
#(
  parameter int                   ADDR_W      = DEF_ADDR_W,
  parameter int                   INSTR_W     = DEF_INSTR_W,
  parameter int                   PC_STEP     = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE = OP_HALT,
  parameter int                   CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  pc_address,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count,
  output fetch_state_e       dbg_state_o
);

  fetch_state_e       state_q,    state_d;
  logic [ADDR_W-1:0]  pc_q,       pc_d;
  logic [INSTR_W-1:0] instr_q,    instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q,    valid_d;
  logic               halted_q,   halted_d;
  logic [CNT_W-1:0]   count_q,    count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= OP_NOP;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    count_d    = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        instr_d    = imem_data;
        instr_pc_d = pc_q;
        if (imem_data == HALT_OPCODE) begin
          // HALT is captured for visibility but never offered to execute.
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d = ST_ISSUE;
          valid_d = 1'b1;
        end
      end

      ST_ISSUE: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          // Sequential step wraps naturally at the address width.
          pc_d = redirect_valid ? redirect_target : pc_q + ADDR_W'(PC_STEP);
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pc_address    = pc_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = valid_q;
  assign halted        = halted_q;
  assign retired_count = count_q;
  assign running       = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
  assign dbg_state_o   = state_q;

endmodule
